// File: rtl/full_adder_bist.sv
// Self-test controller for a 1-bit full adder: walks all eight {a,b,ci} vectors,
// holds each for DWELL cycles and counts mismatches on s/co.
// Optional build macro: FA_BIST_STOP_ON_FAIL_EN ends the run at the first mismatch.
//
// state | meaning
// IDLE  | waiting for start after reset, all outputs low
// APPLY | driving vec onto {a,b,ci}, counting dwell, sampling on the last dwell cycle
// DONE  | run finished, done/pass/err status held until the next start
module full_adder_bist #(
  parameter int DWELL = 4,
  parameter int ERR_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             a,
  output logic             b,
  output logic             ci,
  input  logic             s,
  input  logic             co,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [2:0]       fail_vec,
  output logic             fail_valid
);

  typedef enum logic [1:0] {IDLE, APPLY, DONE} state_t;

`ifdef FA_BIST_STOP_ON_FAIL_EN
  localparam logic STOP_ON_FAIL = 1'b1;
`else
  localparam logic STOP_ON_FAIL = 1'b0;
`endif

  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

  state_t           state;
  logic [2:0]       vec;
  logic [7:0]       cnt;
  logic             exp_s;
  logic             exp_co;
  logic             mism;
  logic [ERR_W-1:0] err_next;

  // Reference is taken from the registered operands actually presented to the adder.
  assign exp_s    = a ^ b ^ ci;
  assign exp_co   = (a & b) | (a & ci) | (b & ci);
  assign mism     = (s != exp_s) || (co != exp_co);
  assign err_next = (err_count == '1) ? err_count : err_count + ERR_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      vec        <= 3'd0;
      cnt        <= 8'd0;
      a          <= 1'b0;
      b          <= 1'b0;
      ci         <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_vec   <= 3'd0;
      fail_valid <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= APPLY;
            vec        <= 3'd0;
            cnt        <= 8'd0;
            {a, b, ci} <= 3'd0;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_vec   <= 3'd0;
            fail_valid <= 1'b0;
          end
        end
        APPLY: begin
          if (cnt == DWELL_LAST) begin
            cnt <= 8'd0;
            if (mism) begin
              err_count <= err_next;
              if (!fail_valid) begin
                fail_vec   <= vec;
                fail_valid <= 1'b1;
              end
            end
            // fail_valid still reflects earlier vectors here, so mism covers the final sample.
            if (vec == 3'd7 || (STOP_ON_FAIL && mism)) begin
              state      <= DONE;
              vec        <= 3'd0;
              {a, b, ci} <= 3'd0;
              busy       <= 1'b0;
              done       <= 1'b1;
              pass       <= !(fail_valid || mism);
            end else begin
              vec        <= vec + 3'd1;
              {a, b, ci} <= vec + 3'd1;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_full_adder_bist.sv
// Randomized bench for full_adder_bist: a fault-injecting adder model feeds the DUT and
// expected status is derived from per-vector fault masks.
module tb_full_adder_bist;

  localparam int DWELL   = 4;
  localparam int ERR_W   = 3;
  localparam int ERR_MAX = (1 << ERR_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             start = 1'b0;
  logic             a, b, ci, s, co;
  logic             busy, done, pass, fail_valid;
  logic [ERR_W-1:0] err_count;
  logic [2:0]       fail_vec;
  logic [7:0]       s_mask = 8'h00;
  logic [7:0]       c_mask = 8'h00;
  int               checks = 0;
  int               errors = 0;

  full_adder_bist #(.DWELL(DWELL), .ERR_W(ERR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a(a), .b(b), .ci(ci), .s(s), .co(co),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_vec(fail_vec), .fail_valid(fail_valid)
  );

  always #5 clk = ~clk;

  // Adder under test: arithmetic sum with per-vector output inversions.
  always_comb begin
    logic [1:0] tot;
    tot = 2'(a) + 2'(b) + 2'(ci);
    s   = tot[0] ^ s_mask[{a, b, ci}];
    co  = tot[1] ^ c_mask[{a, b, ci}];
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench exceeded its time limit");
    $fatal(1, "timeout");
  end

  task automatic run_test(input logic [7:0] sm, input logic [7:0] cm, input int pulse_at,
                          input string name);
    logic [7:0] bad;
    int nmis, first, end_t, exp_err;
    s_mask = sm;
    c_mask = cm;
    bad    = sm | cm;
    nmis   = 0;
    first  = -1;
    for (int v = 0; v < 8; v++) begin
      if (bad[v]) begin
        nmis++;
        if (first < 0) first = v;
      end
    end
    end_t = 8 * DWELL;
`ifdef FA_BIST_STOP_ON_FAIL_EN
    if (first >= 0) begin
      end_t = (first + 1) * DWELL;
      nmis  = 1;
    end
`endif
    exp_err = (nmis > ERR_MAX) ? ERR_MAX : nmis;

    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    checks++;
    if (err_count !== '0 || fail_valid !== 1'b0 || pass !== 1'b0 || fail_vec !== 3'd0) begin
      errors++;
      $display("FAIL %s entry_clear: err=%0d fv=%b pass=%b vec=%0d, required all 0",
               name, err_count, fail_valid, pass, fail_vec);
    end
    for (int t = 0; t < end_t; t++) begin
      checks++;
      if (busy !== 1'b1 || done !== 1'b0 || {a, b, ci} !== 3'(t / DWELL)) begin
        errors++;
        $display("FAIL %s drive t=%0d: busy=%b done=%b abc=%b, required busy=1 done=0 abc=%0d",
                 name, t, busy, done, {a, b, ci}, t / DWELL);
      end
      start = (t == pulse_at);
      @(negedge clk);
    end
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b1 || {a, b, ci} !== 3'd0) begin
      errors++;
      $display("FAIL %s finish: busy=%b done=%b abc=%b, required busy=0 done=1 abc=0",
               name, busy, done, {a, b, ci});
    end
    checks++;
    if (pass !== (nmis == 0)) begin
      errors++;
      $display("FAIL %s pass: got %b, required %b", name, pass, nmis == 0);
    end
    checks++;
    if (err_count !== ERR_W'(exp_err)) begin
      errors++;
      $display("FAIL %s err_count: got %0d, required %0d", name, err_count, exp_err);
    end
    checks++;
    if (fail_valid !== (first >= 0) || fail_vec !== ((first >= 0) ? 3'(first) : 3'd0)) begin
      errors++;
      $display("FAIL %s fail_vec: got valid=%b vec=%0d, required valid=%b vec=%0d",
               name, fail_valid, fail_vec, first >= 0, (first >= 0) ? first : 0);
    end
    // status must hold in DONE
    repeat (2) @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || err_count !== ERR_W'(exp_err)) begin
      errors++;
      $display("FAIL %s hold: done=%b busy=%b err=%0d, required done=1 busy=0 err=%0d",
               name, done, busy, err_count, exp_err);
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    checks++;
    if ({a, b, ci, busy, done, pass, fail_valid} !== 7'd0 || err_count !== '0 || fail_vec !== 3'd0) begin
      errors++;
      $display("FAIL reset_values: abc=%b busy=%b done=%b pass=%b err=%0d fv=%b vec=%0d, required 0",
               {a, b, ci}, busy, done, pass, err_count, fail_valid, fail_vec);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b done=%b, required 0 0", busy, done);
    end
  endtask

  task automatic test_clean();          run_test(8'h00, 8'h00, -1, "clean");         endtask
  task automatic test_s_stuck0();       run_test(8'b1001_0110, 8'h00, -1, "s_stuck0"); endtask
  task automatic test_co_inverted();    run_test(8'h00, 8'hFF, -1, "co_inverted");   endtask
  task automatic test_ignore_start();   run_test(8'h00, 8'h00, 5, "ignore_start");   endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_test(8'($urandom & $urandom), 8'($urandom & $urandom & $urandom), -1, "random");
    end
  endtask

  task automatic test_back_to_back();
    s_mask = 8'h00;
    c_mask = 8'h00;
    @(negedge clk); start = 1'b1;
    @(negedge clk);
    repeat (8 * DWELL) @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || pass !== 1'b1) begin
      errors++;
      $display("FAIL b2b_done: done=%b busy=%b pass=%b, required 1 0 1", done, busy, pass);
    end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || {a, b, ci} !== 3'd0) begin
      errors++;
      $display("FAIL b2b_restart: busy=%b done=%b abc=%b, required 1 0 000", busy, done, {a, b, ci});
    end
    repeat (8 * DWELL) @(negedge clk);
    checks++;
    if (done !== 1'b1 || pass !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second: done=%b pass=%b, required 1 1", done, pass);
    end
  endtask

  task automatic test_reset_midrun();
    s_mask = 8'b1001_0110;
    c_mask = 8'h00;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({a, b, ci, busy, done, pass, fail_valid} !== 7'd0 || err_count !== '0 || fail_vec !== 3'd0) begin
      errors++;
      $display("FAIL midrun_reset: abc=%b busy=%b done=%b pass=%b err=%0d fv=%b vec=%0d, required 0",
               {a, b, ci}, busy, done, pass, err_count, fail_valid, fail_vec);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || {a, b, ci} !== 3'd0) begin
      errors++;
      $display("FAIL midrun_idle: busy=%b done=%b abc=%b, required 0 0 000", busy, done, {a, b, ci});
    end
    run_test(8'h00, 8'h00, -1, "after_reset");
  endtask

  initial begin
    test_reset();
    test_clean();
    test_s_stuck0();
    test_co_inverted();
    test_ignore_start();
    test_clean();
    test_random();
    test_back_to_back();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
